// File: rtl/switchable_clock_divider_pkg.sv
// rtl/switchable_clock_divider_pkg.sv - state encoding and ratio clamp shared by the switchable clock divider
package switchable_clock_divider_pkg;

    typedef enum logic [1:0] {
        STOPPED   = 2'd0,
        RUNNING   = 2'd1,
        SWITCHING = 2'd2
    } state_t;

    // A ratio of 1 cannot produce a high and a low phase, so it runs as 2.
    function automatic logic [31:0] clamp_ratio(input logic [31:0] r);
        return (r == 32'd1) ? 32'd2 : r;
    endfunction

endpackage

// File: rtl/switchable_clock_divider_counter.sv
// rtl/switchable_clock_divider_counter.sv - period counter and phase compare; ratio is captured on load (0 = hold low)
module clock_divider_counter #(
    parameter int RATIO_WIDTH = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [RATIO_WIDTH-1:0] ratio,
    input  logic                   load,
    output logic                   clock_out,
    output logic                   boundary
);

    logic [RATIO_WIDTH-1:0] n;
    logic [RATIO_WIDTH-1:0] count;
    logic [RATIO_WIDTH-1:0] count_next;

    assign boundary   = (n != '0) && (count == n - RATIO_WIDTH'(1));
    assign count_next = boundary ? '0 : count + RATIO_WIDTH'(1);

    always_ff @(posedge clock) begin
        if (reset) begin
            n         <= '0;
            count     <= '0;
            clock_out <= 1'b0;
        end else if (load) begin
            n         <= ratio;
            count     <= '0;
            clock_out <= (ratio != '0);
        end else if (n == '0) begin
            count     <= '0;
            clock_out <= 1'b0;
        end else begin
            count     <= count_next;
            clock_out <= (count_next < (n >> 1));
        end
    end

endmodule

// File: rtl/switchable_clock_divider.sv
// rtl/switchable_clock_divider.sv - glitch-free switchable clock divider; SWITCHABLE_CLOCK_DIVIDER_RISE_PULSE_EN adds rise_pulse
module switchable_clock_divider
    import switchable_clock_divider_pkg::*;
#(
    parameter int RATIO_WIDTH = 8,
    parameter int RESET_RATIO = 0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [RATIO_WIDTH-1:0] ratio,
    input  logic                   ratio_valid,
    output logic                   ratio_ready,
    output logic                   clock_out,
    output logic [RATIO_WIDTH-1:0] active_ratio,
    output logic                   busy
`ifdef SWITCHABLE_CLOCK_DIVIDER_RISE_PULSE_EN
    ,
    output logic                   rise_pulse
`endif
);

    localparam logic [RATIO_WIDTH-1:0] RESET_N = RATIO_WIDTH'(clamp_ratio(32'(RESET_RATIO)));
    localparam state_t RESET_STATE = (RESET_N != '0) ? RUNNING : STOPPED;

    state_t                 state;
    state_t                 next_state;
    logic [RATIO_WIDTH-1:0] pending_ratio;
    logic [RATIO_WIDTH-1:0] next_pending;
    logic [RATIO_WIDTH-1:0] next_active;
    logic [RATIO_WIDTH-1:0] req_n;
    logic [RATIO_WIDTH-1:0] load_ratio;
    logic                   restart;
    logic                   accept;
    logic                   load;
    logic                   boundary;

    assign req_n = RATIO_WIDTH'(clamp_ratio(32'(ratio)));

    // restart marks the first cycle after reset so a reset ratio starts a fresh period.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= RESET_STATE;
            pending_ratio <= '0;
            active_ratio  <= RESET_N;
            restart       <= 1'b1;
        end else begin
            state         <= next_state;
            pending_ratio <= next_pending;
            active_ratio  <= next_active;
            restart       <= 1'b0;
        end
    end

    always_comb begin
        next_state   = state;
        next_pending = pending_ratio;
        next_active  = active_ratio;
        load         = 1'b0;
        load_ratio   = active_ratio;
        accept       = ratio_valid && ratio_ready;
        case (state)
            STOPPED: begin
                if (accept && req_n != '0) begin
                    next_state  = RUNNING;
                    next_active = req_n;
                    load        = 1'b1;
                    load_ratio  = req_n;
                end
            end
            RUNNING: begin
                load = restart;
                if (accept) begin
                    next_state   = SWITCHING;
                    next_pending = req_n;
                end
            end
            SWITCHING: begin
                // Switching only on the boundary keeps every period whole.
                if (boundary) begin
                    load         = 1'b1;
                    load_ratio   = pending_ratio;
                    next_active  = pending_ratio;
                    next_pending = '0;
                    next_state   = (pending_ratio != '0) ? RUNNING : STOPPED;
                end
            end
            default: next_state = STOPPED;
        endcase
    end

    always_comb begin
        ratio_ready = !reset && (state != SWITCHING);
        busy        = (state == SWITCHING);
    end

`ifdef SWITCHABLE_CLOCK_DIVIDER_RISE_PULSE_EN
    assign rise_pulse = !reset && (load ? (load_ratio != '0) : boundary);
`endif

    clock_divider_counter #(
        .RATIO_WIDTH(RATIO_WIDTH)
    ) u_counter (
        .clock    (clock),
        .reset    (reset),
        .ratio    (load_ratio),
        .load     (load),
        .clock_out(clock_out),
        .boundary (boundary)
    );

endmodule
